mdu: RTL

- Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
- Takes the same forwarded operands as the ALU: op1 = rs, op2 = rt.
- Holds the architectural HI/LO registers and produces a busy/stall indication so the hazard unit freezes mult/div/mfhi/mflo/mthi/mtlo while an operation is in flight.
- HI/LO are read combinationally by the EX-stage result mux for mfhi/mflo.

---
 rtl/mdu.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO.
// Result is computed at issue and committed after a fixed busy count.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [63:0]   res;
  logic          wr;

  logic          is_mul, is_div, muldiv;
  logic          issue, commit;
  logic [63:0]   calc;
  logic          calc_wr;

  logic          sgn, sa, sb;
  logic [31:0]   ua, ub, bd, q, r, quo, rem;

  // Decode the operation class
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    sgn    = 1'b0;
    unique case (mdu_op)
      3'd1: begin is_mul = 1'b1; sgn = 1'b1; end
      3'd2: is_mul = 1'b1;
      3'd3: begin is_div = 1'b1; sgn = 1'b1; end
      3'd4: is_div = 1'b1;
      default: ;
    endcase
    muldiv = is_mul | is_div;
  end

  // Issue-time arithmetic: divide via magnitudes, fix signs after
  always_comb begin
    sa   = sgn & op1[31];
    sb   = sgn & op2[31];
    ua   = sa ? (~op1 + 32'd1) : op1;
    ub   = sb ? (~op2 + 32'd1) : op2;
    bd   = (ub == 32'd0) ? 32'd1 : ub;
    q    = ua / bd;
    r    = ua % bd;
    quo  = (sa ^ sb) ? (~q + 32'd1) : q;
    rem  = sa ? (~r + 32'd1) : r;
    calc = {rem, quo};
    calc_wr = 1'b1;
    if (is_mul) begin
      if (sgn)
        calc = {{32{op1[31]}}, op1} * {{32{op2[31]}}, op2};
      else
        calc = {32'd0, op1} * {32'd0, op2};
    end else if (is_div) begin
      calc_wr = (op2 != 32'd0);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && muldiv) state_nx = BUSY;
      BUSY: if (cnt == CW'(1))   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs and datapath strobes
  always_comb begin
    busy      = (state == BUSY);
    issue     = (state == IDLE) & start & muldiv;
    commit    = (state == BUSY) & (cnt == CW'(1));
    stall_req = busy | (start & muldiv);
  end

  // Counter, latched result and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      res <= '0;
      wr  <= 1'b0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (issue) begin
        res <= calc;
        wr  <= calc_wr;
        cnt <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (state == BUSY) begin
        cnt <= cnt - CW'(1);
      end
      if (commit) begin
        if (wr) begin
          hi <= res[63:32];
          lo <= res[31:0];
        end
      end else if (state == IDLE && start) begin
        if (mdu_op == 3'd5) hi <= op1;
        if (mdu_op == 3'd6) lo <= op1;
      end
    end
  end

endmodule
